// File: rtl/lisa_rx_fifo.sv
// Byte FIFO behind lisa_rx8n: a small pull FSM drains the rx8n holding register
// into DEPTH entries and re-presents them through the same rd / d / data_avail handshake.
module lisa_rx_fifo #(
    parameter int DEPTH        = 8,
    parameter int AW           = 3,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_avail,
    input  logic [7:0]    rx_d,
    output logic          rx_rd,
    input  logic          flush,
    input  logic          rd,
    output logic [7:0]    d,
    output logic          data_avail,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
);

    // Handshakes: on the rx8n side a byte is offered while rx_avail = 1 and taken by a
    // single-cycle rx_rd pulse; on the consumer side d is valid while data_avail = 1 and
    // rd in that state pops it at the next edge (rd without data_avail is ignored).

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PULL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    state_t          state_q, state_d;
    logic            rx_rd_q, rx_rd_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic            do_write;
    logic            do_drop;
    logic            do_pop;

    assign full       = count_q[AW];
    assign data_avail = (count_q != '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign rx_rd      = rx_rd_q;
    assign d          = mem_q[rd_ptr_q];

    // Pull FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rx_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_rd_q <= rx_rd_d;
        end
    end

    // Pull FSM: next state. WAIT gives rx8n a cycle to drop rx_avail so a byte is never pulled twice.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rx_avail && (!full || DROP_ON_FULL)) state_d = S_PULL;
            S_PULL:  state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pull FSM: outputs. rx_rd is registered so it is high exactly while in PULL.
    always_comb begin
        rx_rd_d = (state_d == S_PULL);
    end

    assign do_write = (state_q == S_PULL) && !full;
    assign do_drop  = (state_q == S_PULL) && full && DROP_ON_FULL;
    assign do_pop   = rd && data_avail;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({do_write, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf must leave overflow set.
    always_comb begin
        overflow_d = overflow_q;
        if (do_drop)      overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; d is only meaningful while data_avail = 1.
    always_ff @(posedge clk) begin
        if (do_write && !flush) mem_q[wr_ptr_q] <= rx_d;
    end

endmodule

// File: tb/tb_lisa_rx_fifo.sv
// Bench for lisa_rx_fifo: a back-pressure instance (index 0) and a drop-on-full instance (index 1)
// fed by a behavioural rx8n and compared each cycle against a shifting-array FIFO model.
module tb_lisa_rx_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic       rx_avail [2];
  logic [7:0] rx_d     [2];
  logic       rx_rd    [2];
  logic       flush    [2];
  logic       rd       [2];
  logic       clr_ovf  [2];
  logic [7:0] d        [2];
  logic       data_avail [2];
  logic       full     [2];
  logic       overflow [2];
  logic [AW:0] count   [2];

  always #5 clk = ~clk;

  lisa_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_ON_FULL(1'b0)) u_bp (
    .clk(clk), .rst(rst), .rx_avail(rx_avail[0]), .rx_d(rx_d[0]), .rx_rd(rx_rd[0]),
    .flush(flush[0]), .rd(rd[0]), .d(d[0]), .data_avail(data_avail[0]), .full(full[0]),
    .count(count[0]), .overflow(overflow[0]), .clr_ovf(clr_ovf[0])
  );

  lisa_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_ON_FULL(1'b1)) u_drop (
    .clk(clk), .rst(rst), .rx_avail(rx_avail[1]), .rx_d(rx_d[1]), .rx_rd(rx_rd[1]),
    .flush(flush[1]), .rd(rd[1]), .d(d[1]), .data_avail(data_avail[1]), .full(full[1]),
    .count(count[1]), .overflow(overflow[1]), .clr_ovf(clr_ovf[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: FIFO contents as a plain array with element 0 at the head.
  logic [7:0] mq [2][0:DEPTH-1];
  int         msz [2];
  logic       movf [2];

  logic [7:0] feed [2][0:511];
  int feed_n [2];
  int feed_i [2];
  int pulls [2];
  int last_pull [2];
  int stall [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_feed(input int i, input logic [7:0] b);
    feed[i][feed_n[i]] = b;
    feed_n[i]++;
  endtask

  task automatic check_outputs(input int i);
    chk($sformatf("count%0d", i), 32'(count[i]), msz[i]);
    chk($sformatf("data_avail%0d", i), 32'(data_avail[i]), 32'(msz[i] > 0));
    chk($sformatf("full%0d", i), 32'(full[i]), 32'(msz[i] == DEPTH));
    chk($sformatf("overflow%0d", i), 32'(overflow[i]), 32'(movf[i]));
    if (msz[i] > 0) chk($sformatf("d%0d", i), 32'(d[i]), 32'(mq[i][0]));
  endtask

  task automatic model_step(input int i, input logic pull);
    logic was_full;
    was_full = (msz[i] == DEPTH);
    if (pull && was_full && (i == 1)) movf[i] = 1'b1;
    else if (clr_ovf[i]) movf[i] = 1'b0;
    if (flush[i]) begin
      msz[i] = 0;
    end else begin
      if (rd[i] && msz[i] > 0) begin
        for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
        msz[i]--;
      end
      if (pull && !was_full) begin
        mq[i][msz[i]] = rx_d[i];
        msz[i]++;
      end
    end
  endtask

  task automatic tick();
    logic pulled [2];
    for (int i = 0; i < 2; i++) begin
      if (!rx_avail[i] && !rx_rd[i] && feed_i[i] < feed_n[i]) begin
        rx_avail[i] = 1'b1;
        rx_d[i] = feed[i][feed_i[i]];
        feed_i[i]++;
      end
      pulled[i] = rx_rd[i];
      model_step(i, pulled[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (pulled[i]) rx_avail[i] = 1'b0;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      if (rx_rd[i]) begin
        chk($sformatf("pull_gap%0d", i), 32'(cyc - last_pull[i] >= 3), 1);
        chk($sformatf("pull_src%0d", i), 32'(rx_avail[i]), 1);
        if (i == 0) chk("pull_not_full0", 32'(msz[0] < DEPTH), 1);
        last_pull[i] = cyc;
        pulls[i]++;
      end
      if (rx_avail[i] && !rx_rd[i] && (msz[i] < DEPTH || i == 1)) stall[i]++;
      else stall[i] = 0;
      chk($sformatf("pull_stall%0d", i), 32'(stall[i] <= 3), 1);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msz[i] = 0;
      movf[i] = 1'b0;
      pulls[i] = 0;
      last_pull[i] = -10;
      stall[i] = 0;
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      for (int i = 0; i < 2; i++) rd[i] = (msz[i] > 0);
      tick();
      done = 1'b1;
      for (int i = 0; i < 2; i++)
        if (msz[i] != 0 || rx_avail[i] || feed_i[i] < feed_n[i]) done = 1'b0;
    end
    chk("drain_done", 32'(done), 1);
    for (int i = 0; i < 2; i++) rd[i] = 1'b0;
    run(3);
    for (int i = 0; i < 2; i++) pulls[i] = 0;
  endtask

  initial begin
    logic seen;
    int maxc;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_avail[i] = 1'b0; rx_d[i] = 8'h00; flush[i] = 1'b0; rd[i] = 1'b0; clr_ovf[i] = 1'b0;
      feed_n[i] = 0; feed_i[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      chk($sformatf("reset_rx_rd%0d", i), 32'(rx_rd[i]), 0);
    end
    rst = 1'b0;

    // Single byte: one pulse, visible the cycle after PULL, popped by one rd.
    push_feed(0, 8'h55);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (rx_rd[0]) seen = 1'b1;
    end
    chk("t1_pull_seen", 32'(seen), 1);
    tick();
    chk("t1_avail", 32'(data_avail[0]), 1);
    chk("t1_d", 32'(d[0]), 32'h55);
    chk("t1_count", 32'(count[0]), 1);
    rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    chk("t1_avail_after_pop", 32'(data_avail[0]), 0);
    run(5);
    chk("t1_pulses", pulls[0], 1);
    drain();

    // Fill with back-pressure: ninth byte waits in rx8n until a slot frees.
    for (int b = 1; b <= 9; b++) push_feed(0, 8'(b));
    run(40);
    chk("t2_full", 32'(full[0]), 1);
    chk("t2_count", 32'(count[0]), 8);
    chk("t2_held", 32'(rx_avail[0]), 1);
    chk("t2_pulls", pulls[0], 8);
    for (int k = 0; k < 40; k++) begin
      rd[0] = (msz[0] > 0) && (k < 8);
      tick();
    end
    rd[0] = 1'b0;
    chk("t2_pulls_after", pulls[0], 9);
    chk("t2_ninth", 32'(d[0]), 32'h09);
    drain();

    // Drop-on-full: the extra byte is pulled and discarded.
    for (int b = 1; b <= 8; b++) push_feed(1, 8'(b));
    push_feed(1, 8'hAA);
    run(40);
    chk("t3_pulls", pulls[1], 9);
    chk("t3_overflow", 32'(overflow[1]), 1);
    chk("t3_count", 32'(count[1]), 8);
    chk("t3_head", 32'(d[1]), 32'h01);
    clr_ovf[1] = 1'b1;
    tick();
    clr_ovf[1] = 1'b0;
    chk("t3_ovf_clr", 32'(overflow[1]), 0);
    drain();

    // Streaming with immediate pops: pointers wrap many times.
    for (int k = 0; k < 20; k++) push_feed(0, 8'($urandom_range(0, 255)));
    maxc = 0;
    for (int k = 0; k < 90; k++) begin
      rd[0] = (msz[0] > 0);
      tick();
      if (int'(count[0]) > maxc) maxc = int'(count[0]);
    end
    chk("t4_max_count", 32'(maxc <= 2), 1);
    chk("t4_pulls", pulls[0], 20);
    rd[0] = 1'b1;
    run(3);
    rd[0] = 1'b0;
    chk("t4_empty_rd", 32'(count[0]), 0);
    drain();

    // Flush with a concurrent pop.
    push_feed(0, 8'h11); push_feed(0, 8'h22); push_feed(0, 8'h33);
    run(15);
    chk("t5_count3", 32'(count[0]), 3);
    flush[0] = 1'b1;
    rd[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    rd[0] = 1'b0;
    chk("t5_count0", 32'(count[0]), 0);
    chk("t5_avail0", 32'(data_avail[0]), 0);
    push_feed(0, 8'h3C);
    run(6);
    chk("t5_d", 32'(d[0]), 32'h3C);
    drain();

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) == 0 && feed_n[i] - feed_i[i] < 4 && feed_n[i] < 500)
          push_feed(i, 8'($urandom_range(0, 255)));
        rd[i] = ($urandom_range(0, 3) == 0);
        flush[i] = ($urandom_range(0, 49) == 0);
        clr_ovf[i] = ($urandom_range(0, 24) == 0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0;
      clr_ovf[i] = 1'b0;
    end
    drain();

    // Reset in the middle of a pull: the byte stays in rx8n and is pulled again.
    push_feed(0, 8'h77);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (rx_rd[0]) seen = 1'b1;
    end
    chk("t6_pull_seen", 32'(seen), 1);
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6_rx_rd%0d", i), 32'(rx_rd[i]), 0);
      check_outputs(i);
    end
    @(negedge clk);
    rst = 1'b0;
    run(10);
    chk("t6_pulls", pulls[0], 1);
    chk("t6_count", 32'(count[0]), 1);
    chk("t6_d", 32'(d[0]), 32'h77);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
